// File: rtl/act_pkg.sv
// Shared definitions for the activation pipeline: mode encodings, FRAC-derived
// constants for the piecewise-linear sigmoid, and a signed saturation helper.
package act_pkg;

    typedef enum logic [1:0] {
        ACT_RELU    = 2'd0,
        ACT_LEAKY   = 2'd1,
        ACT_HTANH   = 2'd2,
        ACT_SIGMOID = 2'd3
    } act_mode_e;

    function automatic int one_f(input int frac);
        return 1 << frac;
    endfunction

    // Constants and breakpoints are floor(k * 2^frac), written as exact rationals.
    function automatic int c1_f(input int frac);
        return (1 << frac) >> 1;            // 0.5
    endfunction

    function automatic int c2_f(input int frac);
        return (5 << frac) >> 3;            // 0.625
    endfunction

    function automatic int c3_f(input int frac);
        return (27 << frac) >> 5;           // 0.84375
    endfunction

    function automatic int bp_lo_f(input int frac);
        return 1 << frac;                   // 1.0
    endfunction

    function automatic int bp_mid_f(input int frac);
        return (19 << frac) >> 3;           // 2.375
    endfunction

    function automatic int bp_hi_f(input int frac);
        return 5 << frac;                   // 5.0
    endfunction

    function automatic int sat_w(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/act_lane.sv
// One activation lane: stage 1 captures sign, |x| and range flags; stage 2
// selects and saturates the result for the mode travelling with the beat.
module act_lane
    import act_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int FRAC        = 4,
    parameter int LEAKY_SHIFT = 5
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             ld1,
    input  logic             ld2,
    input  logic [WIDTH-1:0] x,
    input  logic [1:0]       mode_s1,
    output logic [WIDTH-1:0] y
);

    localparam int ONE    = one_f(FRAC);
    localparam int C1     = c1_f(FRAC);
    localparam int C2     = c2_f(FRAC);
    localparam int C3     = c3_f(FRAC);
    localparam int BP_LO  = bp_lo_f(FRAC);
    localparam int BP_MID = bp_mid_f(FRAC);
    localparam int BP_HI  = bp_hi_f(FRAC);
    localparam int MAXP   = (1 << (WIDTH - 1)) - 1;

    logic signed [WIDTH:0]   xe;
    logic signed [WIDTH:0]   abs_e;
    logic        [WIDTH-1:0] a_n;

    always_comb begin
        xe    = {x[WIDTH-1], x};
        abs_e = x[WIDTH-1] ? -xe : xe;
        // Only the most-negative input overflows the positive range.
        a_n   = (abs_e > (WIDTH+1)'(MAXP)) ? WIDTH'(MAXP) : abs_e[WIDTH-1:0];
    end

    logic                    s1_neg;
    logic        [WIDTH-1:0] s1_a;
    logic signed [WIDTH-1:0] s1_x;
    logic                    s1_ge_lo, s1_ge_mid, s1_ge_hi;
    logic                    s1_gt_one, s1_lt_mone;

    // NOTE: datapath registers carry no reset; the valid bits in the top level
    // decide whether their contents mean anything, which keeps the reset tree small.
    always_ff @(posedge iClk) begin
        if (ld1) begin
            s1_neg     <= x[WIDTH-1];
            s1_a       <= a_n;
            s1_x       <= x;
            s1_ge_lo   <= int'(a_n) >= BP_LO;
            s1_ge_mid  <= int'(a_n) >= BP_MID;
            s1_ge_hi   <= int'(a_n) >= BP_HI;
            s1_gt_one  <= xe > (WIDTH+1)'(ONE);
            s1_lt_mone <= xe < -((WIDTH+1)'(ONE));
        end
    end

    int                xi;
    int                ai;
    int                f;
    int                r;
    logic [WIDTH-1:0]  y_n;

    always_comb begin
        xi = int'(s1_x);
        ai = int'(s1_a);
        f  = 0;
        r  = xi;
        case (act_mode_e'(mode_s1))
            ACT_RELU:  r = s1_neg ? 0 : xi;
            ACT_LEAKY: r = s1_neg ? (xi >>> LEAKY_SHIFT) : xi;
            ACT_HTANH: r = s1_gt_one ? ONE : (s1_lt_mone ? -ONE : xi);
            ACT_SIGMOID: begin
                if (s1_ge_hi)       f = ONE;
                else if (s1_ge_mid) f = (ai >> 5) + C3;
                else if (s1_ge_lo)  f = (ai >> 3) + C2;
                else                f = (ai >> 2) + C1;
                r = s1_neg ? (ONE - f) : f;
                r = (r < 0) ? 0 : ((r > ONE) ? ONE : r);
            end
            default: r = xi;
        endcase
        y_n = WIDTH'(sat_w(r, WIDTH));
    end

    // The output register is reset because out_data must read zero until the
    // first delivered beat.
    always_ff @(posedge iClk) begin
        if (!iRst)    y <= '0;
        else if (ld2) y <= y_n;
    end

endmodule

// File: rtl/act_func_pipe.sv
// Multi-lane activation unit: two-stage pipeline with valid/ready stall control,
// per-beat mode carried alongside the data.
module act_func_pipe
    import act_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int FRAC        = 4,
    parameter int LANES       = 4,
    parameter int LEAKY_SHIFT = 5
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_mode,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [1:0]             out_mode
);

    logic       s1_valid;
    logic [1:0] s1_mode;
    logic       adv1, adv2, ld1, ld2;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1 || !iRst;
    assign ld1      = in_valid && adv1;
    // NOTE: stage 2 loads only real beats, so the unreset stage-1 contents never
    // reach out_data while no beat has been delivered.
    assign ld2      = s1_valid && adv2;

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_mode  <= 2'd0;
        end else begin
            if (adv1) s1_valid  <= in_valid;
            if (adv2) out_valid <= s1_valid;
            if (ld2)  out_mode  <= s1_mode;
        end
    end

    always_ff @(posedge iClk) begin
        if (ld1) s1_mode <= in_mode;
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        act_lane #(
            .WIDTH      (WIDTH),
            .FRAC       (FRAC),
            .LEAKY_SHIFT(LEAKY_SHIFT)
        ) u_lane (
            .iClk   (iClk),
            .iRst   (iRst),
            .ld1    (ld1),
            .ld2    (ld2),
            .x      (in_data[g*WIDTH +: WIDTH]),
            .mode_s1(s1_mode),
            .y      (out_data[g*WIDTH +: WIDTH])
        );
    end

endmodule
